turbo_qpp_interleaver_pp: RTL
=============================

# turbo_qpp_interleaver_pp

Parametrised successor to the single-block turbo interleaver. It permutes one turbo code block, size selected per block, with the LTE QPP rule pi(i) = (f1·i + f2·i²) mod K. It also supports the inverse permutation (de-interleave) for the decoder path, a generic word width, and two ping-pong banks, so block n+1 can be received while block n drains. It sits between the CRC attachment stage (upstream) and the turbo encoder or decoder (downstream).

## Interface
- DW, 8: word width in bits; K0 and K1 must be multiples of DW.
- K0, 1056: block size selected when cbs=0.
- F1_0, 17: f1 for K0.
- F2_0, 66: f2 for K0.
- K1, 6144: block size selected when cbs=1.
- F1_1, 263: f1 for K1.
- F2_1, 480: f2 for K1.
- Derived, not user-settable: KMAX = max(K0, K1), which sets bank depth in bits.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; the block is held in reset while reset=0.
- vld_crc  in  1  upstream word valid.
- rdy_out  in  1  downstream ready.
- cbs  in  1  block size select; sampled with the first accepted word of a block.
- deint  in  1  0 = interleave, 1 = de-interleave; sampled with the first accepted word of a block.
- data_in  in  DW  input word; data_in[DW-1] is the lowest bit index of the word.
- rdy_crc  out  1  block can accept a word.
- vld_out  out  1  data_out valid.
- last_byte  out  1  marks the final word of a block; asserted only while vld_out=1.
- data_out  out  DW  output word; same MSB-first bit order as data_in.

## Operation
- Input transfer: vld_crc & rdy_crc at a rising edge. Output transfer: vld_out & rdy_out at a rising edge.
- Word j carries bits DW·j … DW·j+DW-1. A block is K/DW words.
- Interleave: output bit n = input bit pi(n). Bits are written sequentially and read at pi addresses.
- De-interleave: output bit pi(i) = input bit i. Bits are written at pi addresses and read sequentially.
- Addresses are generated recursively, never with a multiplier on the full index:
  - pi(i+1) = (pi(i) + g(i)) mod K.
  - g(i+1) = (g(i) + 2·f2) mod K, with g(0) = (f1 + f2) mod K.
  - DW lanes are advanced per cycle; every sum is reduced by a single conditional subtract of K.
  - Internal widths are clog2(KMAX)+1 bits.
- Each bank has its own state: EMPTY, FILL, FULL, DRAIN.
  - EMPTY→FILL on the first accepted input word; cbs and deint are latched into the bank.
  - FILL→FULL on the accepting edge of word K/DW-1.
  - FULL→DRAIN on the first output transfer.
  - DRAIN→EMPTY on the transfer that has last_byte=1.
- The write pointer toggles banks at FILL→FULL. The read pointer toggles banks at DRAIN→EMPTY.
- rdy_crc=1 iff the write bank is EMPTY or FILL.
- vld_out=1 iff the read bank is FULL or DRAIN.
- The two banks may hold different cbs/deint settings; each drains with its own latched settings.
- If the read bank returns to EMPTY on the same edge that the write bank fills, both events take effect; no word is lost.
- cbs and deint changes mid-block are ignored.

## Timing
- Reset values: rdy_crc=0, vld_out=0, last_byte=0, data_out=0, both banks EMPTY, pointers at bank 0.
- rdy_crc rises on the first rising edge after reset deasserts.
- Latency: vld_out rises the cycle after the edge that accepts the final input word, with output word 0 presented.
- Sustained throughput is 1 word/cycle in and 1 word/cycle out, concurrently.
- While vld_out=1 and rdy_out=0, data_out and last_byte hold stable.
- data_out=0 whenever vld_out=0.
- With both banks occupied, rdy_crc=0 until the read bank empties. rdy_crc rises the cycle after the last_byte transfer.
- An asynchronous reset mid-block discards both banks. Outputs take their reset values immediately.

## Test plan
- K0 interleave, single set bit: data_in = 0 except word 10 = 0x10 (bit 83). Required: output word 0 = 0x40, all other words 0, last_byte only on word 131.
- K0 de-interleave: word 0 = 0x40, rest 0. Required: output word 10 = 0x10, all others 0. Also check an impulse at bit 4 maps to output bit 68: word 8 = 0x08.
- K1 interleave: input bit 743 = 1 (word 92 = 0x01). Required: output word 0 = 0x40, 768 words, last_byte on word 767.
- Ping-pong with backpressure: hold rdy_out=0 and stream two K0 blocks. Required: rdy_crc stays 1 for 264 accepted words, then 0. Raise rdy_out and check rdy_crc returns the cycle after the 132nd output. Both blocks must match the golden 1056-bit vectors.
- Mixed settings: block A has cbs=0, deint=0; block B has cbs=1, deint=1, back-to-back. Required: A drains 132 words interleaved, then B drains 768 words de-interleaved, with no gap when rdy_out=1.
- Random rdy_out/vld_crc toggling plus reset asserted mid-fill. Required: outputs go to reset values at once, and the next full block matches golden.

Source files
------------

// File: rtl/turbo_qpp_interleaver_pp.sv
// turbo_qpp_interleaver_pp: ping-pong LTE QPP turbo interleaver / de-interleaver.
// Two bit-addressed banks; one fills while the other drains. QPP addresses are
// produced recursively, DW lanes per cycle, each lane one add/conditional-subtract.

// One QPP recursion step: pi' = (pi + g) mod k, g' = (g + 2*f2) mod k.
module qpp_lane_step #(
  parameter int AW = 14
) (
  input  logic [AW-1:0] k,
  input  logic [AW-1:0] tf2,
  input  logic [AW-1:0] pi_i,
  input  logic [AW-1:0] g_i,
  output logic [AW-1:0] pi_o,
  output logic [AW-1:0] g_o
);
  logic [AW-1:0] ps, gs;

  // operands are always < k, so a single conditional subtract reduces the sum
  always_comb begin
    ps   = pi_i + g_i;
    gs   = g_i + tf2;
    pi_o = (ps >= k) ? ps - k : ps;
    g_o  = (gs >= k) ? gs - k : gs;
  end
endmodule

// DW chained lane steps: lane addresses for one word plus the state for the next word.
module qpp_addr_gen #(
  parameter int DW = 8,
  parameter int AW = 14,
  parameter int IW = 13
) (
  input  logic [AW-1:0]          k,
  input  logic [AW-1:0]          tf2,
  input  logic [AW-1:0]          pi0,
  input  logic [AW-1:0]          g0,
  output logic [DW-1:0][IW-1:0]  pi_lane,
  output logic [AW-1:0]          pi_nxt,
  output logic [AW-1:0]          g_nxt
);
  logic [AW-1:0] pc [DW+1];
  logic [AW-1:0] gc [DW+1];

  assign pc[0]  = pi0;
  assign gc[0]  = g0;
  assign pi_nxt = pc[DW];
  assign g_nxt  = gc[DW];

  genvar l;
  generate
    for (l = 0; l < DW; l++) begin : g_lane
      qpp_lane_step #(.AW(AW)) u_step (
        .k    (k),
        .tf2  (tf2),
        .pi_i (pc[l]),
        .g_i  (gc[l]),
        .pi_o (pc[l+1]),
        .g_o  (gc[l+1])
      );
      // pi < k <= KMAX <= 2**IW, so the top bit is always zero
      assign pi_lane[l] = pc[l][IW-1:0];
    end
  endgenerate
endmodule

module turbo_qpp_interleaver_pp #(
  parameter int DW   = 8,
  parameter int K0   = 1056,
  parameter int F1_0 = 17,
  parameter int F2_0 = 66,
  parameter int K1   = 6144,
  parameter int F1_1 = 263,
  parameter int F2_1 = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_crc,
  input  logic          rdy_out,
  input  logic          cbs,
  input  logic          deint,
  input  logic [DW-1:0] data_in,
  output logic          rdy_crc,
  output logic          vld_out,
  output logic          last_byte,
  output logic [DW-1:0] data_out
);
  localparam int KMAX = (K0 > K1) ? K0 : K1;
  localparam int IW   = $clog2(KMAX);
  localparam int AW   = IW + 1;

  localparam logic [AW-1:0] KA0   = AW'(K0);
  localparam logic [AW-1:0] KA1   = AW'(K1);
  localparam logic [AW-1:0] G0_0  = AW'((F1_0 + F2_0) % K0);
  localparam logic [AW-1:0] G0_1  = AW'((F1_1 + F2_1) % K1);
  localparam logic [AW-1:0] TF2_0 = AW'((2 * F2_0) % K0);
  localparam logic [AW-1:0] TF2_1 = AW'((2 * F2_1) % K1);
  localparam logic [AW-1:0] LAST0 = AW'(K0 - DW);
  localparam logic [AW-1:0] LAST1 = AW'(K1 - DW);
  localparam logic [AW-1:0] STEP  = AW'(DW);

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_st_t;

  bank_st_t       bst    [2];
  logic           bcbs   [2];
  logic           bdeint [2];
  logic           wptr, rptr, rdy_en;
  logic [AW-1:0]  w_seq_q, w_pi_q, w_g_q;
  logic [AW-1:0]  r_seq_q, r_pi_q, r_g_q;
  logic [KMAX-1:0] mem [2];

  // write side
  bank_st_t              w_st;
  logic                  w_empty, w_cbs, w_deint, w_last, w_acc;
  logic [AW-1:0]         w_k, w_tf2, w_pi0, w_g0, w_pi_nxt, w_g_nxt;
  logic [DW-1:0][IW-1:0] w_pil, w_addr;

  // read side
  bank_st_t              r_st;
  logic                  r_full, r_cbs, r_deint, r_xfer;
  logic [AW-1:0]         r_k, r_tf2, r_pi0, r_g0, r_pi_nxt, r_g_nxt;
  logic [DW-1:0][IW-1:0] r_pil, r_addr;

  // write bank control: first word of a block takes cbs/deint straight from the inputs
  always_comb begin
    w_st    = bst[wptr];
    w_empty = (w_st == EMPTY);
    w_cbs   = w_empty ? cbs   : bcbs[wptr];
    w_deint = w_empty ? deint : bdeint[wptr];
    w_k     = w_cbs ? KA1 : KA0;
    w_tf2   = w_cbs ? TF2_1 : TF2_0;
    w_pi0   = w_empty ? '0 : w_pi_q;
    w_g0    = w_empty ? (w_cbs ? G0_1 : G0_0) : w_g_q;
    w_last  = (w_seq_q == (w_cbs ? LAST1 : LAST0));
    rdy_crc = rdy_en & ((w_st == EMPTY) || (w_st == FILL));
    w_acc   = vld_crc & rdy_crc;
    for (int l = 0; l < DW; l++)
      w_addr[l] = w_deint ? w_pil[l] : IW'(w_seq_q + AW'(l));
  end

  qpp_addr_gen #(.DW(DW), .AW(AW), .IW(IW)) u_wgen (
    .k       (w_k),
    .tf2     (w_tf2),
    .pi0     (w_pi0),
    .g0      (w_g0),
    .pi_lane (w_pil),
    .pi_nxt  (w_pi_nxt),
    .g_nxt   (w_g_nxt)
  );

  // read bank control: a FULL bank restarts the recursion from pi(0)=0
  always_comb begin
    r_st    = bst[rptr];
    r_full  = (r_st == FULL);
    vld_out = (r_st == FULL) || (r_st == DRAIN);
    r_cbs   = bcbs[rptr];
    r_deint = bdeint[rptr];
    r_k     = r_cbs ? KA1 : KA0;
    r_tf2   = r_cbs ? TF2_1 : TF2_0;
    r_pi0   = r_full ? '0 : r_pi_q;
    r_g0    = r_full ? (r_cbs ? G0_1 : G0_0) : r_g_q;
    for (int l = 0; l < DW; l++)
      r_addr[l] = r_deint ? IW'(r_seq_q + AW'(l)) : r_pil[l];
  end

  qpp_addr_gen #(.DW(DW), .AW(AW), .IW(IW)) u_rgen (
    .k       (r_k),
    .tf2     (r_tf2),
    .pi0     (r_pi0),
    .g0      (r_g0),
    .pi_lane (r_pil),
    .pi_nxt  (r_pi_nxt),
    .g_nxt   (r_g_nxt)
  );

  // output word: lane 0 is the MSB; forced to zero while nothing is valid
  always_comb begin
    data_out  = '0;
    last_byte = vld_out & (r_seq_q == (r_cbs ? LAST1 : LAST0));
    r_xfer    = vld_out & rdy_out;
    for (int l = 0; l < DW; l++)
      data_out[DW-1-l] = vld_out & mem[rptr][r_addr[l]];
  end

  // bank state machines, pointers and address recursion state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bst[0]    <= EMPTY;
      bst[1]    <= EMPTY;
      bcbs[0]   <= 1'b0;
      bcbs[1]   <= 1'b0;
      bdeint[0] <= 1'b0;
      bdeint[1] <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      rdy_en    <= 1'b0;
      w_seq_q   <= '0;
      w_pi_q    <= '0;
      w_g_q     <= '0;
      r_seq_q   <= '0;
      r_pi_q    <= '0;
      r_g_q     <= '0;
    end else begin
      rdy_en <= 1'b1;
      // write and read banks are never the same bank while both are active
      if (w_acc) begin
        if (w_empty) begin
          bcbs[wptr]   <= cbs;
          bdeint[wptr] <= deint;
        end
        if (w_last) begin
          bst[wptr] <= FULL;
          wptr      <= ~wptr;
          w_seq_q   <= '0;
        end else begin
          bst[wptr] <= FILL;
          w_seq_q   <= w_seq_q + STEP;
        end
        w_pi_q <= w_pi_nxt;
        w_g_q  <= w_g_nxt;
      end
      if (r_xfer) begin
        if (last_byte) begin
          bst[rptr] <= EMPTY;
          rptr      <= ~rptr;
          r_seq_q   <= '0;
        end else begin
          bst[rptr] <= DRAIN;
          r_seq_q   <= r_seq_q + STEP;
        end
        r_pi_q <= r_pi_nxt;
        r_g_q  <= r_g_nxt;
      end
    end
  end

  // bit storage: DW bit writes per accepted word; contents need no reset
  always_ff @(posedge clk) begin
    if (w_acc)
      for (int l = 0; l < DW; l++)
        mem[wptr][w_addr[l]] <= data_in[DW-1-l];
  end
endmodule
